uart_periph: RTL and testbench
==============================

// Module: uart_periph
// PURPOSE
//  Memory-mapped UART peripheral on the CPU data bus, next to DataMem: the CPU decodes ALUOut as the address and drives rd/wr/wdata.
//  Serialises TX bytes and deserialises RX frames (8N1, LSB first); raises irqout for the Control IRQ input.
//  Read data is combinational so single-cycle lw completes in one cycle; all state updates on posedge clk.
// PARAMETERS
//  BASE_ADDR  32'h4000_0018  address of TXD; RXD = BASE+4, CON = BASE+8
//  BAUD_DIV   5208           clk cycles per bit (50 MHz / 9600); must be >= 4
// PORTS
//  clk      in   1   clock
//  reset    in   1   asynchronous, active-low
//  rd       in   1   bus read strobe
//  wr       in   1   bus write strobe
//  addr     in   32  byte address; only BASE..BASE+8 (word aligned) decoded
//  wdata    in   32  write data
//  rdata    out  32  read data; 0 when !rd or address not decoded
//  uart_rx  in   1   serial input, asynchronous to clk
//  uart_tx  out  1   serial output, idle high
//  irqout   out  1   level interrupt request
// BEHAVIOUR
//  Reset: uart_tx=1, irqout=0, TXD=RXD=CON=0, both FSMs IDLE; mid-frame reset aborts at once (tx high asynchronously).
//  Registers:
//   TXD  R/W [7:0]: write while TX idle latches byte and starts frame; write while TX_BUSY ignored (TXD unchanged).
//   RXD  R   [7:0]: last good byte; rd&&addr==RXD at an edge clears RX_VALID.
//   CON  [0] TX_IRQ_EN rw, [1] RX_IRQ_EN rw, [2] TX_DONE, [3] RX_VALID, [4] TX_BUSY, [5] OVERRUN, [6] FERR;
//        writes touch only [1:0]; rd of CON at an edge clears [2], [5], [6]. Upper bits read 0.
//  irqout = (TX_IRQ_EN & TX_DONE) | (RX_IRQ_EN & RX_VALID), registered-flag based (no extra delay beyond flags).
//  TX FSM IDLE->START->DATA->STOP->IDLE; each state bit lasts exactly BAUD_DIV cycles.
//   Accepted TXD write at edge k: uart_tx=0 from edge k for BAUD_DIV cycles, then d0..d7, then stop=1.
//   TX_BUSY=1 from edge k to end of STOP (10*BAUD_DIV cycles); TX_DONE set on the edge returning to IDLE.
//   Back-to-back: write accepted on the cycle TX_BUSY reads 0.
//  RX path: uart_rx through 2-FF synchroniser (2-cycle latency), idle assumed high.
//   IDLE: falling edge of synced rx -> START; count BAUD_DIV/2, resample: low -> DATA, high -> IDLE (glitch reject).
//   DATA: sample every BAUD_DIV cycles, 8 bits into shift reg LSB first -> STOP.
//   STOP: sample after BAUD_DIV; high -> RXD<=byte, RX_VALID<=1, OVERRUN<=1 if RX_VALID was already 1 (new byte overwrites);
//         low -> FERR<=1, byte discarded, RXD/RX_VALID unchanged. Always -> IDLE (requires line high before next start).
//  Simultaneous events: flag set beats read-clear in the same cycle (RX_VALID stays 1; TX_DONE stays 1);
//   CON write with TX_DONE set same edge: enables update, TX_DONE set. TXD write on final STOP cycle ignored.
//  Counters: baud counters 0..BAUD_DIV-1 wrap, width $clog2(BAUD_DIV); bit index 0..7 in 3-bit counter.
//  rd and wr both asserted: write performed; rdata still driven combinationally.
// TESTING (BAUD_DIV=4 in sim)
//  1 Reset then idle 20 cycles -> uart_tx=1, irqout=0, rdata(CON)=0.
//  2 wr TXD=0x55, TX_IRQ_EN=1 -> tx 0,1,0,1,0,1,0,1,0,1 each 4 cycles; TX_BUSY 40 cycles; then TX_DONE=1, irqout=1; read CON -> irqout=0.
//  3 Write TXD=0xAA while busy from test 2 -> ignored; TXD reads 0x55, frame unchanged.
//  4 Drive rx frame 0xA3 with good stop, RX_IRQ_EN=1 -> RXD=0xA3, RX_VALID=1, irqout=1; read RXD -> RX_VALID=0, irqout=0.
//  5 Two frames 0x11,0x22 without reading -> RXD=0x22, OVERRUN=1; frame with stop=0 -> FERR=1, RXD unchanged; 1-cycle low glitch -> nothing.
//  6 Assert reset mid TX and mid RX frame -> uart_tx=1 immediately, all flags 0; next TXD write sends clean frame.

Source files
------------

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers on the CPU data bus, combinational
// read data, level interrupt from the TX_DONE / RX_VALID flags.
module uart_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
    parameter int          BAUD_DIV  = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irqout
);
    localparam int          CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [31:0] TXD_ADDR  = BASE_ADDR;
    localparam logic [31:0] RXD_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [31:0] CON_ADDR  = BASE_ADDR + 32'd8;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]      txd_q, txd_d, rxd_q, rxd_d, rx_shift_q, rx_shift_d;
    logic            tx_line_q, tx_line_d;
    logic [1:0]      rx_sync_q, rx_sync_d;
    logic            rx_prev_q, rx_prev_d;
    logic            tx_irq_en_q, tx_irq_en_d, rx_irq_en_q, rx_irq_en_d;
    logic            tx_done_q, tx_done_d, rx_valid_q, rx_valid_d;
    logic            overrun_q, overrun_d, ferr_q, ferr_d;

    logic sel_txd, sel_rxd, sel_con, tx_accept, con_wr, con_rd, rxd_rd;
    logic tx_busy, tx_done_set, rx_good, rx_ferr, rx_bit;
    logic [31:0] con_val;
    logic unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    assign sel_txd   = (addr == TXD_ADDR);
    assign sel_rxd   = (addr == RXD_ADDR);
    assign sel_con   = (addr == CON_ADDR);
    assign tx_busy   = (tx_state_q != S_IDLE);
    assign tx_accept = wr && sel_txd && !tx_busy;
    assign con_wr    = wr && sel_con;
    assign con_rd    = rd && sel_con;
    assign rxd_rd    = rd && sel_rxd;
    assign rx_bit    = rx_sync_q[1];

    assign con_val = {25'd0, ferr_q, overrun_q, tx_busy, rx_valid_q, tx_done_q,
                      rx_irq_en_q, tx_irq_en_q};

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd)      rdata = {24'd0, txd_q};
            else if (sel_rxd) rdata = {24'd0, rxd_q};
            else if (sel_con) rdata = con_val;
        end
    end

    assign irqout  = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_valid_q);
    assign uart_tx = tx_line_q;

    // TX: line level is registered from the next state so the pin never glitches.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        txd_d       = txd_q;
        tx_done_set = 1'b0;
        unique case (tx_state_q)
            S_IDLE: if (tx_accept) begin
                txd_d      = wdata[7:0];
                tx_state_d = S_START;
                tx_cnt_d   = '0;
            end
            S_START: if (tx_cnt_q == BAUD_LAST) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = S_DATA;
            end else tx_cnt_d = tx_cnt_q + CW'(1);
            S_DATA: if (tx_cnt_q == BAUD_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                else                  tx_bit_d   = tx_bit_q + 3'd1;
            end else tx_cnt_d = tx_cnt_q + CW'(1);
            S_STOP: if (tx_cnt_q == BAUD_LAST) begin
                tx_cnt_d    = '0;
                tx_state_d  = S_IDLE;
                tx_done_set = 1'b1;
            end else tx_cnt_d = tx_cnt_q + CW'(1);
            default: tx_state_d = S_IDLE;
        endcase
        unique case (tx_state_d)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = txd_d[tx_bit_d];
            default: tx_line_d = 1'b1;
        endcase
    end

    // RX: start is re-checked half a bit later so short low glitches are dropped.
    always_comb begin
        rx_sync_d  = {rx_sync_q[0], uart_rx};
        rx_prev_d  = rx_bit;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_bit) begin
                rx_state_d = S_START;
                rx_cnt_d   = '0;
            end
            S_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_bit ? S_IDLE : S_DATA;
            end else rx_cnt_d = rx_cnt_q + CW'(1);
            S_DATA: if (rx_cnt_q == BAUD_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_bit, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q + CW'(1);
            S_STOP: if (rx_cnt_q == BAUD_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = S_IDLE;
                rx_good    = rx_bit;
                rx_ferr    = !rx_bit;
            end else rx_cnt_d = rx_cnt_q + CW'(1);
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Flag updates: a set in the same cycle wins over a read-clear.
    always_comb begin
        rxd_d       = rx_good ? rx_shift_q : rxd_q;
        rx_valid_d  = rx_good ? 1'b1 : (rxd_rd ? 1'b0 : rx_valid_q);
        overrun_d   = (rx_good && rx_valid_q) ? 1'b1 : (con_rd ? 1'b0 : overrun_q);
        ferr_d      = rx_ferr ? 1'b1 : (con_rd ? 1'b0 : ferr_q);
        tx_done_d   = tx_done_set ? 1'b1 : (con_rd ? 1'b0 : tx_done_q);
        tx_irq_en_d = con_wr ? wdata[0] : tx_irq_en_q;
        rx_irq_en_d = con_wr ? wdata[1] : rx_irq_en_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q  <= S_IDLE;
            rx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            rx_bit_q    <= '0;
            txd_q       <= '0;
            rxd_q       <= '0;
            rx_shift_q  <= '0;
            tx_line_q   <= 1'b1;
            rx_sync_q   <= 2'b11;
            rx_prev_q   <= 1'b1;
            tx_irq_en_q <= 1'b0;
            rx_irq_en_q <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            rx_state_q  <= rx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            rx_bit_q    <= rx_bit_d;
            txd_q       <= txd_d;
            rxd_q       <= rxd_d;
            rx_shift_q  <= rx_shift_d;
            tx_line_q   <= tx_line_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
            tx_irq_en_q <= tx_irq_en_d;
            rx_irq_en_q <= rx_irq_en_d;
            tx_done_q   <= tx_done_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            ferr_q      <= ferr_d;
        end
    end
endmodule

// File: tb/tb_uart_periph.sv
// Scoreboard bench for uart_periph: bus reads and TX frames are queued as
// expectations and checked by independent monitors.
module tb_uart_periph;
    localparam int          B    = 4;
    localparam logic [31:0] TXD  = 32'h4000_0018;
    localparam logic [31:0] RXD  = 32'h4000_001C;
    localparam logic [31:0] CON  = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset, rd, wr, uart_rx;
    logic [31:0] addr, wdata, rdata;
    logic        uart_tx, irqout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cyc = 0;

    logic [31:0] exp_rd_q[$];
    string       exp_rd_tag[$];
    logic [7:0]  exp_tx_q[$];

    uart_periph #(.BASE_ADDR(32'h4000_0018), .BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irqout(irqout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read monitor: every cycle with rd high consumes one queued expectation.
    always @(negedge clk) begin
        if (rd) begin
            if (exp_rd_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
            else chk(exp_rd_tag.pop_front(), rdata, exp_rd_q.pop_front());
        end
    end

    // TX monitor: samples the first cycle of each bit; frames cut by reset are dropped.
    initial begin
        logic [9:0] frame;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (reset && uart_tx === 1'b0) begin
                frame = '0;
                aborted = 1'b0;
                for (int c = 1; c < 10 * B; c++) begin
                    @(negedge clk);
                    if (!reset) aborted = 1'b1;
                    if (c % B == 0) frame[c / B] = uart_tx;
                end
                if (!aborted) begin
                    if (exp_tx_q.size() == 0) chk("unexpected_tx_frame", {22'd0, frame}, 32'd0);
                    else chk("tx_frame", {22'd0, frame}, {22'd0, 1'b1, exp_tx_q.pop_front(), 1'b0});
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr_cyc = cyc;
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        @(posedge clk); #1;
        rd = 1'b1; addr = a;
        exp_rd_q.push_back(exp);
        exp_rd_tag.push_back(tag);
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (B) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_irq(input string name);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (irqout) break;
        end
        chk(name, {31'd0, irqout}, 32'd1);
    endtask

    initial begin
        int t2;
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_tx_high", {31'd0, uart_tx}, 32'd1);
            chk("idle_irq_low", {31'd0, irqout}, 32'd0);
        end
        bus_read(CON, 32'h00, "reset_con");

        // 2/3: transmit 0x55 with TX irq, ignored write while busy
        bus_write(CON, 32'h1);
        bus_write(TXD, 32'h55);
        t2 = wr_cyc;
        exp_tx_q.push_back(8'h55);
        bus_read(CON, 32'h11, "con_busy");
        bus_write(TXD, 32'hAA);
        bus_read(TXD, 32'h55, "txd_kept_while_busy");
        @(negedge clk);
        chk("irq_low_while_busy", {31'd0, irqout}, 32'd0);
        wait_irq("tx_done_irq");
        chk("tx_busy_cycles", cyc - t2, 32'd40);
        bus_read(CON, 32'h05, "con_tx_done");
        @(negedge clk);
        chk("irq_cleared_by_con_read", {31'd0, irqout}, 32'd0);
        bus_read(CON, 32'h01, "con_after_clear");

        // 4: receive 0xA3 with RX irq
        bus_write(CON, 32'h2);
        send_rx(8'hA3, 1'b1);
        wait_irq("rx_valid_irq");
        bus_read(CON, 32'h0A, "con_rx_valid");
        bus_read(RXD, 32'hA3, "rxd_a3");
        @(negedge clk);
        chk("irq_cleared_by_rxd_read", {31'd0, irqout}, 32'd0);
        bus_read(CON, 32'h02, "con_rx_consumed");

        // 5: overrun, framing error, glitch
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (6) @(posedge clk);
        bus_read(CON, 32'h2A, "con_overrun");
        bus_read(RXD, 32'h22, "rxd_overwritten");
        send_rx(8'h5A, 1'b0);
        repeat (6) @(posedge clk);
        bus_read(CON, 32'h42, "con_ferr");
        bus_read(RXD, 32'h22, "rxd_kept_on_ferr");
        @(posedge clk); #1 uart_rx = 1'b0;
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        bus_read(CON, 32'h02, "con_after_glitch");

        // 6: reset in the middle of a TX and an RX frame
        send_rx(8'h77, 1'b1);
        repeat (6) @(posedge clk);
        bus_write(CON, 32'h3);
        bus_write(TXD, 32'h3C);
        #1 uart_rx = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;
        #1;
        chk("reset_tx_async_high", {31'd0, uart_tx}, 32'd1);
        chk("reset_irq_low", {31'd0, irqout}, 32'd0);
        bus_read(CON, 32'h00, "reset_con_mid");
        bus_read(TXD, 32'h00, "reset_txd_mid");
        bus_read(RXD, 32'h00, "reset_rxd_mid");
        uart_rx = 1'b1;
        @(negedge clk); reset = 1'b1;
        repeat (50) @(posedge clk);
        bus_read(CON, 32'h00, "con_after_reset");
        bus_write(TXD, 32'h96);
        exp_tx_q.push_back(8'h96);
        for (int n = 0; n < 200 && exp_tx_q.size() != 0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        bus_read(CON, 32'h04, "con_done_after_reset");
        chk("irq_disabled_after_reset", {31'd0, irqout}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            if (exp_tx_q.size() == 0 && exp_rd_q.size() == 0) break;
            @(negedge clk);
        end
        chk("pending_expectations", exp_tx_q.size() + exp_rd_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
